// File: rtl/clken_pkg.sv
// ----------------------------------------------------------------------------
// clken_pkg
//
// Shared definitions for the multi-channel clock-enable generator
// (clock_enable_gen / clken_channel).
//
// Contents:
//   MODE_W        width of a channel mode field
//   DEF_DIV       default divisor loaded at reset (10 Hz phase from 50 MHz)
//   clken_mode_t  channel mode: OFF, RUN, ONESHOT, STEP
//   mode_counts() true for the modes in which the divider counter advances
// ----------------------------------------------------------------------------
package clken_pkg;

    localparam int MODE_W = 2;

    localparam int unsigned DEF_DIV = 32'd2500000;

    typedef enum logic [MODE_W-1:0] {
        MODE_OFF     = 2'b00,
        MODE_RUN     = 2'b01,
        MODE_ONESHOT = 2'b10,
        MODE_STEP    = 2'b11
    } clken_mode_t;

    // Only RUN and ONESHOT advance the counter; OFF and STEP hold it at 0.
    function automatic logic mode_counts(input clken_mode_t m);
        return (m == MODE_RUN) || (m == MODE_ONESHOT);
    endfunction

endpackage

// File: rtl/clken_channel.sv
// ----------------------------------------------------------------------------
// clken_channel
//
// One divider channel of clock_enable_gen. Holds the counter, the active and
// shadow divisors, the mode, the phase flip-flop and the sticky done flag.
//
// Ports:
//   clk           system clock
//   resetN        asynchronous active-low reset
//   wr_i          configuration write addressed to this channel
//   wr_div_i      divisor carried by the write
//   wr_mode_i     mode carried by the write (clken_mode_t encoding)
//   wr_restart_i  apply the divisor now and clear the counter
//   step_i        single-cycle step event (already synchronised)
//   tick_o        registered one-cycle enable pulse
//   phase_o       registered square wave, toggles on every tick
//   busy_o        mode is not OFF
//   done_o        sticky ONESHOT completion flag
// ----------------------------------------------------------------------------
module clken_channel #(
    parameter int          CNT_W      = 32,
    parameter int unsigned DEF_DIV    = 32'd2500000,
    parameter logic [1:0]  RESET_MODE = 2'b01
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             wr_i,
    input  logic [CNT_W-1:0] wr_div_i,
    input  logic [1:0]       wr_mode_i,
    input  logic             wr_restart_i,
    input  logic             step_i,
    output logic             tick_o,
    output logic             phase_o,
    output logic             busy_o,
    output logic             done_o
);
    import clken_pkg::*;

    clken_mode_t      mode_q, mode_d;
    clken_mode_t      wr_mode;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] shd_q, shd_d;
    logic             tick_q, tick_d;
    logic             phase_q, phase_d;
    logic             done_q, done_d;

    logic counting;
    logic term_cnt;
    logic wr_off;
    logic apply_now;
    logic fire;

    assign wr_mode  = clken_mode_t'(wr_mode_i);
    assign counting = mode_counts(mode_q);
    // The active divisor only changes while the counter is 0, so cnt_q never
    // exceeds div_q and an equality compare is enough for terminal count.
    assign term_cnt = counting && (cnt_q == div_q);
    assign wr_off   = wr_i && (wr_mode == MODE_OFF);

    // The new divisor bypasses the shadow when the period is ending anyway,
    // when a restart is requested, when the counter is idle (OFF/STEP), or
    // when a ONESHOT is (re)armed so that it runs a full new period.
    assign apply_now = wr_i && (wr_restart_i || !counting ||
                                (wr_mode == MODE_ONESHOT) || term_cnt);

    // Writing OFF in the terminal-count cycle swallows that tick.
    assign fire = !wr_off &&
                  (term_cnt || ((mode_q == MODE_STEP) && step_i));

    always_comb begin
        mode_d  = mode_q;
        div_d   = div_q;
        shd_d   = shd_q;
        done_d  = done_q;
        tick_d  = fire;
        phase_d = fire ? ~phase_q : phase_q;

        if (!counting || term_cnt) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        if (term_cnt) begin
            div_d = shd_q;
            if (mode_q == MODE_ONESHOT) begin
                mode_d = MODE_OFF;
                done_d = 1'b1;
            end
        end

        // A write overrides the automatic updates above.
        if (wr_i) begin
            mode_d = wr_mode;
            shd_d  = wr_div_i;
            done_d = 1'b0;
            if (apply_now) begin
                div_d = wr_div_i;
                cnt_d = '0;
            end
            if (!mode_counts(wr_mode)) begin
                cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            mode_q  <= clken_mode_t'(RESET_MODE);
            cnt_q   <= '0;
            div_q   <= CNT_W'(DEF_DIV);
            shd_q   <= CNT_W'(DEF_DIV);
            tick_q  <= 1'b0;
            phase_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            shd_q   <= shd_d;
            tick_q  <= tick_d;
            phase_q <= phase_d;
            done_q  <= done_d;
        end
    end

    assign tick_o  = tick_q;
    assign phase_o = phase_q;
    assign busy_o  = (mode_q != MODE_OFF);
    assign done_o  = done_q;

endmodule

// File: rtl/clock_enable_gen.sv
// ----------------------------------------------------------------------------
// clock_enable_gen
//
// Multi-channel runtime-programmable clock-enable generator. Every channel
// produces a registered single-cycle tick, a divided square-wave phase, a
// busy flag and a sticky ONESHOT done flag, all in the clk domain.
//
// Build option:
//   CLKEN_STEP_EN  when defined, adds the stepIn push-button input. It is
//                  synchronised (2 flops) and edge-detected; each rising edge
//                  ticks every channel in STEP mode once. When undefined,
//                  STEP mode behaves like OFF (busy still reads 1).
//
// Ports:
//   clk          system clock
//   resetN       asynchronous active-low reset
//   stepIn       asynchronous step button (CLKEN_STEP_EN only)
//   cfgWrEn      configuration write strobe
//   cfgChan      target channel
//   cfgDiv       new divisor
//   cfgMode      new mode: 00 OFF, 01 RUN, 10 ONESHOT, 11 STEP
//   cfgRestart   apply the divisor immediately and clear the counter
//   tick         per-channel one-cycle enable
//   phase        per-channel square wave
//   busy         per-channel mode != OFF
//   done         per-channel sticky ONESHOT completion
//   cfgErr       one-cycle pulse after a write to a non-existent channel
// ----------------------------------------------------------------------------
module clock_enable_gen #(
    parameter int          NUM_CH     = 4,
    parameter int          CNT_W      = 32,
    parameter int unsigned DEF_DIV    = clken_pkg::DEF_DIV,
    parameter logic [1:0]  RESET_MODE = 2'b01,
    parameter int          CH_IDX_W   = 2
) (
    input  logic                         clk,
    input  logic                         resetN,
`ifdef CLKEN_STEP_EN
    input  logic                         stepIn,
`endif
    input  logic                         cfgWrEn,
    input  logic [CH_IDX_W-1:0]          cfgChan,
    input  logic [CNT_W-1:0]             cfgDiv,
    input  logic [clken_pkg::MODE_W-1:0] cfgMode,
    input  logic                         cfgRestart,
    output logic [NUM_CH-1:0]            tick,
    output logic [NUM_CH-1:0]            phase,
    output logic [NUM_CH-1:0]            busy,
    output logic [NUM_CH-1:0]            done,
    output logic                         cfgErr
);
    logic [NUM_CH-1:0] chan_hit;
    logic              step_pulse;
    logic              cfg_err_q;

`ifdef CLKEN_STEP_EN
    // [0],[1] form the synchroniser; [2] is the previous synchronised value
    // for rising-edge detection. The channel registers the tick one edge
    // later, giving three edges from first-flop capture to tick.
    logic [2:0] step_sync_q;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            step_sync_q <= '0;
        end else begin
            step_sync_q <= {step_sync_q[1:0], stepIn};
        end
    end

    assign step_pulse = step_sync_q[1] & ~step_sync_q[2];
`else
    assign step_pulse = 1'b0;
`endif

    // An address matching no channel raises cfgErr and touches nothing.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= cfgWrEn && !(|chan_hit);
        end
    end

    assign cfgErr = cfg_err_q;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        assign chan_hit[gi] = (cfgChan == CH_IDX_W'(gi));

        clken_channel #(
            .CNT_W      (CNT_W),
            .DEF_DIV    (DEF_DIV),
            .RESET_MODE (RESET_MODE)
        ) u_ch (
            .clk          (clk),
            .resetN       (resetN),
            .wr_i         (cfgWrEn && chan_hit[gi]),
            .wr_div_i     (cfgDiv),
            .wr_mode_i    (cfgMode),
            .wr_restart_i (cfgRestart),
            .step_i       (step_pulse),
            .tick_o       (tick[gi]),
            .phase_o      (phase[gi]),
            .busy_o       (busy[gi]),
            .done_o       (done[gi])
        );
    end

endmodule

// File: tb/tb_clock_enable_gen.sv
// ----------------------------------------------------------------------------
// tb_clock_enable_gen
//
// Drives clock_enable_gen with directed scenarios followed by random writes
// and step activity. The reference model tracks, per channel, the absolute
// edge number at which the next tick is due instead of a counter value.
// ----------------------------------------------------------------------------
module tb_clock_enable_gen;

    localparam int NUM_CH   = 4;
    localparam int CNT_W    = 16;
    localparam int CH_IDX_W = 3;
    localparam int DEFDIV   = 3;

    localparam int M_OFF = 0;
    localparam int M_RUN = 1;
    localparam int M_ONE = 2;
    localparam int M_STP = 3;

    logic                clk;
    logic                resetN;
    logic                stepIn;
    logic                cfgWrEn;
    logic [CH_IDX_W-1:0] cfgChan;
    logic [CNT_W-1:0]    cfgDiv;
    logic [1:0]          cfgMode;
    logic                cfgRestart;
    logic [NUM_CH-1:0]   tick;
    logic [NUM_CH-1:0]   phase;
    logic [NUM_CH-1:0]   busy;
    logic [NUM_CH-1:0]   done;
    logic                cfgErr;

    clock_enable_gen #(
        .NUM_CH     (NUM_CH),
        .CNT_W      (CNT_W),
        .DEF_DIV    (DEFDIV),
        .RESET_MODE (2'b01),
        .CH_IDX_W   (CH_IDX_W)
    ) dut (
        .clk        (clk),
        .resetN     (resetN),
`ifdef CLKEN_STEP_EN
        .stepIn     (stepIn),
`endif
        .cfgWrEn    (cfgWrEn),
        .cfgChan    (cfgChan),
        .cfgDiv     (cfgDiv),
        .cfgMode    (cfgMode),
        .cfgRestart (cfgRestart),
        .tick       (tick),
        .phase      (phase),
        .busy       (busy),
        .done       (done),
        .cfgErr     (cfgErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    int  edge_n;
    int  m_mode  [NUM_CH];
    int  m_div   [NUM_CH];
    int  m_shd   [NUM_CH];
    int  m_next  [NUM_CH];
    bit  m_phase [NUM_CH];
    bit  m_done  [NUM_CH];
    bit  samples [$];

    logic [NUM_CH-1:0] exp_tick;
    logic [NUM_CH-1:0] exp_phase;
    logic [NUM_CH-1:0] exp_busy;
    logic [NUM_CH-1:0] exp_done;
    logic              exp_err;

    task automatic model_reset();
        edge_n = 0;
        samples.delete();
        for (int c = 0; c < NUM_CH; c++) begin
            m_mode[c]  = M_RUN;
            m_div[c]   = DEFDIV;
            m_shd[c]   = DEFDIV;
            m_next[c]  = DEFDIV + 1;
            m_phase[c] = 1'b0;
            m_done[c]  = 1'b0;
        end
    endtask

    task automatic check_vec(input string tag, input logic [NUM_CH-1:0] obs,
                             input logic [NUM_CH-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s edge=%0d observed=%b expected=%b", tag, edge_n, obs, expv);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s edge=%0d observed=%b expected=%b", tag, edge_n, obs, expv);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s edge=%0d observed=%0d expected=%0d", tag, edge_n, obs, expv);
        end
    endtask

    // Drive one clock of stimulus, advance the model by one edge and
    // compare every output 1 time unit after the edge.
    task automatic cyc(input bit w, input int ch, input int d, input int m, input bit r);
        bit step_ev, cnt_on, tc, wc, kill, fire, apply;
        int n;
        cfgWrEn    = w;
        cfgChan    = CH_IDX_W'(ch);
        cfgDiv     = CNT_W'(d);
        cfgMode    = 2'(m);
        cfgRestart = r;
        @(posedge clk);
        edge_n++;
        samples.push_back(stepIn);
        n = samples.size();
        step_ev = 1'b0;
`ifdef CLKEN_STEP_EN
        // Button level first captured at edge k ticks at edge k+2.
        if (n >= 3) step_ev = samples[n-3] && ((n < 4) || !samples[n-4]);
`endif
        exp_err = w && (ch >= NUM_CH);
        for (int c = 0; c < NUM_CH; c++) begin
            cnt_on = (m_mode[c] == M_RUN) || (m_mode[c] == M_ONE);
            tc     = cnt_on && (m_next[c] == edge_n);
            wc     = w && (ch == c);
            kill   = wc && (m == M_OFF);
            fire   = !kill && (tc || ((m_mode[c] == M_STP) && step_ev));
            exp_tick[c] = fire;
            if (fire) m_phase[c] = !m_phase[c];
            if (tc) begin
                m_div[c]  = m_shd[c];
                m_next[c] = edge_n + m_div[c] + 1;
                if (m_mode[c] == M_ONE) begin
                    m_mode[c] = M_OFF;
                    m_done[c] = 1'b1;
                end
            end
            if (wc) begin
                apply     = r || !cnt_on || (m == M_ONE) || tc;
                m_mode[c] = m;
                m_shd[c]  = d;
                m_done[c] = 1'b0;
                if (apply) begin
                    m_div[c]  = d;
                    m_next[c] = edge_n + d + 1;
                end
            end
            exp_phase[c] = m_phase[c];
            exp_busy[c]  = (m_mode[c] != M_OFF);
            exp_done[c]  = m_done[c];
        end
        #1;
        check_vec("tick", tick, exp_tick);
        check_vec("phase", phase, exp_phase);
        check_vec("busy", busy, exp_busy);
        check_vec("done", done, exp_done);
        check_bit("cfgErr", cfgErr, exp_err);
        cfgWrEn = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_vec({tag, "_tick"}, tick, '0);
        check_vec({tag, "_phase"}, phase, '0);
        check_vec({tag, "_done"}, done, '0);
        check_vec({tag, "_busy"}, busy, '1);
        check_bit({tag, "_cfgErr"}, cfgErr, 1'b0);
    endtask

    int cnt;
    int guard;
    int exp_steps;

    initial begin
        resetN     = 1'b0;
        stepIn     = 1'b0;
        cfgWrEn    = 1'b0;
        cfgChan    = '0;
        cfgDiv     = '0;
        cfgMode    = '0;
        cfgRestart = 1'b0;
        model_reset();

        // Reset state while held.
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        $display("reset held: outputs checked");

        @(negedge clk);
        resetN = 1'b1;

        // RUN from reset with divisor 3: ticks at edges 4, 8, 12.
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            cyc(0, 0, 0, 0, 0);
            if (tick[0]) cnt++;
        end
        check_int("run_ticks_ch0", cnt, 3);
        $display("run from reset: %0d ticks on ch0 in 12 edges", cnt);

        // ch1 divisor 9 written while its counter is 1, no restart.
        idle(1);
        cyc(1, 1, 9, M_RUN, 0);
        $display("write ch1 div=9 restart=0");
        idle(25);

        // ch2 ONESHOT with divisor 5.
        cyc(1, 2, 5, M_ONE, 0);
        $display("write ch2 ONESHOT div=5");
        idle(10);
        check_bit("oneshot_busy2", busy[2], 1'b0);
        check_bit("oneshot_done2", done[2], 1'b1);

        // Write to a channel that does not exist.
        cyc(1, 5, 1, M_OFF, 1);
        check_bit("cfgerr_pulse", cfgErr, 1'b1);
        $display("write chan=5: cfgErr=%b", cfgErr);
        idle(2);

        // OFF written in ch0's terminal-count cycle, then RUN with div 0.
        guard = 0;
        while ((m_next[0] != edge_n + 1) && (guard < 50)) begin
            idle(1);
            guard++;
        end
        check_bit("tc_search_bound", guard < 50, 1'b1);
        cyc(1, 0, 7, M_OFF, 0);
        check_bit("off_at_tc_tick0", tick[0], 1'b0);
        $display("write ch0 OFF at terminal count: tick0=%b", tick[0]);
        idle(3);
        cyc(1, 0, 0, M_RUN, 0);
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 0, 0, 0);
            if (tick[0]) cnt++;
        end
        check_int("div0_ticks_ch0", cnt, 5);
        $display("ch0 RUN div=0: %0d ticks in 5 edges", cnt);

        // ch3 STEP with the button held for 20 cycles.
        cyc(1, 3, 4, M_STP, 0);
        stepIn = 1'b1;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(0, 0, 0, 0, 0);
            if (tick[3]) cnt++;
        end
        stepIn = 1'b0;
        idle(4);
`ifdef CLKEN_STEP_EN
        exp_steps = 1;
`else
        exp_steps = 0;
`endif
        check_int("step_held_ticks", cnt, exp_steps);
        $display("ch3 STEP held 20 cycles: %0d ticks", cnt);

        // Random writes and button activity.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) stepIn = !stepIn;
            if ($urandom_range(0, 3) == 0) begin
                cyc(1, int'($urandom_range(0, 5)), int'($urandom_range(0, 12)),
                    int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
            end else begin
                idle(1);
            end
        end
        stepIn = 1'b0;
        $display("random phase: 600 cycles done");

        // Asynchronous reset in the middle of a cycle.
        #2;
        resetN = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        $display("async reset mid-cycle: outputs checked");
        repeat (2) @(negedge clk);
        resetN = 1'b1;
        model_reset();
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            cyc(0, 0, 0, 0, 0);
            if (tick[1]) cnt++;
        end
        check_int("post_reset_ticks_ch1", cnt, 2);
        $display("after reset: %0d ticks on ch1 in 8 edges", cnt);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
